// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU datapath types.
//   word_t  - native 32-bit machine word
//   aluop_t - 4-bit ALU operation code
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [3:0] {
      ALU_ADD = 4'h0,
      ALU_SUB = 4'h1,
      ALU_AND = 4'h2,
      ALU_OR  = 4'h3,
      ALU_XOR = 4'h4,
      ALU_SLL = 4'h5,
      ALU_SRL = 4'h6,
      ALU_SLT = 4'h7
   } aluop_t;

endpackage

// File: rtl/fpga_types_pkg.sv
// fpga_types_pkg: shared types for board-level exercisers.
//   alu_seq_state_t - entry sequencer state; the codes are shown on the LEDs.
//   KEY_*           - bit positions of the push-buttons.
package fpga_types_pkg;

   typedef enum logic [2:0] {
      LOAD_A  = 3'd0,
      LOAD_B  = 3'd1,
      LOAD_OP = 3'd2,
      EXEC    = 3'd3,
      SHOW    = 3'd4
   } alu_seq_state_t;

   localparam int KEY_ENTER = 0;
   localparam int KEY_NEXT  = 1;
   localparam int KEY_CLEAR = 2;
   localparam int KEY_WIN   = 3;

endpackage

// File: rtl/alu_if.sv
// alu_if: connection bundle between an ALU and its controller.
//   PortA/PortB in, ALUOP in, OutputPort out, Zero/Negative/Overflow out.
interface alu_if #(parameter int W = $bits(cpu_types_pkg::word_t));
   import cpu_types_pkg::*;

   logic [W-1:0] PortA;
   logic [W-1:0] PortB;
   aluop_t       ALUOP;
   logic [W-1:0] OutputPort;
   logic         Zero;
   logic         Negative;
   logic         Overflow;

   modport alu  (input  PortA, PortB, ALUOP, output OutputPort, Zero, Negative, Overflow);
   modport ctrl (output PortA, PortB, ALUOP, input  OutputPort, Zero, Negative, Overflow);
endinterface

// File: rtl/alu.sv
// alu: purely combinational ALU.
//   aif (alu modport): operands, op code in; result and Zero/Negative/Overflow out.
//   Overflow is signed overflow for ADD/SUB and 0 for every other op.
module alu
   import cpu_types_pkg::*;
#(
   parameter int W = 32
)(
   alu_if.alu aif
);
   localparam int SH_W = $clog2(W);

   logic [W-1:0] res;
   logic         ovf;

   always_comb begin
      res = '0;
      ovf = 1'b0;
      case (aif.ALUOP)
         ALU_ADD: begin
            res = aif.PortA + aif.PortB;
            ovf = (aif.PortA[W-1] == aif.PortB[W-1]) && (res[W-1] != aif.PortA[W-1]);
         end
         ALU_SUB: begin
            res = aif.PortA - aif.PortB;
            ovf = (aif.PortA[W-1] != aif.PortB[W-1]) && (res[W-1] != aif.PortA[W-1]);
         end
         ALU_AND: res = aif.PortA & aif.PortB;
         ALU_OR:  res = aif.PortA | aif.PortB;
         ALU_XOR: res = aif.PortA ^ aif.PortB;
         ALU_SLL: res = aif.PortA << aif.PortB[SH_W-1:0];
         ALU_SRL: res = aif.PortA >> aif.PortB[SH_W-1:0];
         ALU_SLT: res = W'($signed(aif.PortA) < $signed(aif.PortB));
         default: res = '0;
      endcase
   end

   assign aif.OutputPort = res;
   assign aif.Zero       = (res == '0);
   assign aif.Negative   = res[W-1];
   assign aif.Overflow   = ovf;

endmodule

// File: rtl/alu_fpga_seq_key_cond.sv
// key_cond: conditions one active-low push-button.
//   clk, rst_n   - clock, async active-low reset
//   key_n        - raw button level (low = pressed)
//   press        - one-cycle pulse per debounced press
// The counter saturates one past the threshold, so a held button fires once
// and only re-arms after the synced level goes high and clears the count.
module key_cond #(
   parameter int SYNC_STAGES  = 2,
   parameter int DEBOUNCE_CYC = 500000
)(
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press
);
   localparam int              CNT_W    = $clog2(DEBOUNCE_CYC + 2);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYC);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DEBOUNCE_CYC + 1);

   logic [SYNC_STAGES-1:0] sync;
   logic [CNT_W-1:0]       cnt;
   logic                   level;

   assign level = sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= '1;   // idle-high so reset never looks like a press
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], key_n};
         if (level)
            cnt <= '0;
         else if (cnt != CNT_SAT)
            cnt <= cnt + CNT_W'(1);
         press <= !level && (cnt == CNT_DONE);
      end
   end

endmodule

// File: rtl/alu_fpga_seq.sv
// alu_fpga_seq: board-level ALU exerciser.
//   CLK, nRST - clock, async active-low reset
//   SW        - data chunk in [CHUNK_W-1:0], op code in [3:0], chain mode in [SW_W-1]
//   KEY       - active-low buttons: [0] enter, [1] next, [2] clear, [3] window
//   LEDR      - CHUNK_W-bit window of the view word, window index above it
//   LEDG      - [0] zero [1] neg [2] overflow [3] sticky ovf [4] chain mode [7:5] state
// Operands wider than the switch bank are built by shifting chunks in from the
// right. In SHOW, next with chain mode set feeds the result back in as A.
module alu_fpga_seq
   import cpu_types_pkg::*;
   import fpga_types_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int SW_W         = 18,
   parameter int CHUNK_W      = 16,
   parameter int SYNC_STAGES  = 2,
   parameter int DEBOUNCE_CYC = 500000
)(
   input  logic              CLK,
   input  logic              nRST,
   input  logic [SW_W-1:0]   SW,
   input  logic [3:0]        KEY,
   output logic [SW_W-1:0]   LEDR,
   output logic [7:0]        LEDG
);
   localparam int               NWIN     = DATA_W / CHUNK_W;
   localparam int               IDX_W    = (NWIN > 1) ? $clog2(NWIN) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NWIN - 1);

   if ((DATA_W % CHUNK_W) != 0 || CHUNK_W > SW_W - 2 || SYNC_STAGES < 2) begin : g_bad_cfg
      $error("alu_fpga_seq: illegal DATA_W/CHUNK_W/SW_W/SYNC_STAGES combination");
   end

   // ---------------- buttons ----------------
   logic [3:0] press;
   logic       p_clr, p_next, p_ent, p_win;

   for (genvar k = 0; k < 4; k++) begin : g_key
      key_cond #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key (
         .clk   (CLK),
         .rst_n (nRST),
         .key_n (KEY[k]),
         .press (press[k])
      );
   end

   // clear beats next beats enter; window is independent
   assign p_clr  = press[KEY_CLEAR];
   assign p_next = press[KEY_NEXT]  & ~p_clr;
   assign p_ent  = press[KEY_ENTER] & ~press[KEY_NEXT] & ~p_clr;
   assign p_win  = press[KEY_WIN];

   // chain-mode switch is synchronised; it is the only switch that reaches an LED
   logic [SYNC_STAGES-1:0] mode_sync;
   logic                   mode;
   logic                   unused_sw;

   assign mode      = mode_sync[SYNC_STAGES-1];
   assign unused_sw = ^SW[SW_W-2:CHUNK_W];

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) mode_sync <= '0;
      else       mode_sync <= {mode_sync[SYNC_STAGES-2:0], SW[SW_W-1]};
   end

   // ---------------- datapath registers ----------------
   alu_seq_state_t state, state_nx;
   logic [DATA_W-1:0] a, b, result;
   aluop_t            op;
   logic              zero, neg, ovf, sticky;
   logic [IDX_W-1:0]  idx;

   alu_if #(.W(DATA_W)) aif ();
   alu #(.W(DATA_W)) u_alu (.aif(aif));

   assign aif.PortA = a;
   assign aif.PortB = b;
   assign aif.ALUOP = op;

   // ---------------- FSM ----------------
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= LOAD_A;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (p_clr) begin
         state_nx = LOAD_A;
      end else begin
         case (state)
            LOAD_A:  if (p_next) state_nx = LOAD_B;
            LOAD_B:  if (p_next) state_nx = LOAD_OP;
            LOAD_OP: if (p_next) state_nx = EXEC;
            EXEC:    state_nx = SHOW;
            SHOW: begin
               if (p_next)     state_nx = mode ? LOAD_B : LOAD_A;
               else if (p_ent) state_nx = EXEC;
            end
            default: state_nx = LOAD_A;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         a      <= '0;
         b      <= '0;
         result <= '0;
         op     <= aluop_t'('0);
         zero   <= 1'b0;
         neg    <= 1'b0;
         ovf    <= 1'b0;
         sticky <= 1'b0;
         idx    <= '0;
      end else if (p_clr) begin
         a      <= '0;
         b      <= '0;
         result <= '0;
         op     <= aluop_t'('0);
         zero   <= 1'b0;
         neg    <= 1'b0;
         ovf    <= 1'b0;
         sticky <= 1'b0;
         idx    <= '0;
      end else begin
         case (state)
            // the cast keeps the low DATA_W bits, shifting the top chunk out
            LOAD_A:  if (p_ent) a <= DATA_W'({a, SW[CHUNK_W-1:0]});
            LOAD_B:  if (p_ent) b <= DATA_W'({b, SW[CHUNK_W-1:0]});
            LOAD_OP: if (p_ent) op <= aluop_t'(SW[3:0]);
            EXEC: begin
               result <= aif.OutputPort;
               zero   <= aif.Zero;
               neg    <= aif.Negative;
               ovf    <= aif.Overflow;
               sticky <= sticky | aif.Overflow;
            end
            SHOW: begin
               if (p_next) begin
                  a <= mode ? result : '0;
                  b <= '0;
               end
            end
            default: ;
         endcase

         if (state_nx != state)
            idx <= '0;
         else if (p_win)
            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end
   end

   // ---------------- display ----------------
   logic [DATA_W-1:0] view;

   always_comb begin
      view = '0;
      case (state)
         LOAD_A:  view = a;
         LOAD_B:  view = b;
         LOAD_OP: view[3:0] = op;
         default: view = result;
      endcase
   end

   assign LEDR = {(SW_W - CHUNK_W)'(idx), view[int'(idx) * CHUNK_W +: CHUNK_W]};
   assign LEDG = {state, mode, sticky, ovf, neg, zero};

endmodule

// File: tb/tb_alu_fpga_seq.sv
// tb_alu_fpga_seq: scoreboard bench for alu_fpga_seq (DEBOUNCE_CYC=4).
// Stimulus tasks drive buttons/switches, advance a behavioural model and push
// the expected LED image; a monitor pops and compares on each check request.
module tb_alu_fpga_seq;
   import cpu_types_pkg::*;

   localparam int DW = 32, SWW = 18, CW = 16, SS = 2, DB = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [SWW-1:0] sw = '0;
   logic [3:0]     key = 4'hF;
   logic [SWW-1:0] ledr;
   logic [7:0]     ledg;

   always #5 clk = ~clk;

   alu_fpga_seq #(
      .DATA_W(DW), .SW_W(SWW), .CHUNK_W(CW), .SYNC_STAGES(SS), .DEBOUNCE_CYC(DB)
   ) dut (
      .CLK(clk), .nRST(rst_n), .SW(sw), .KEY(key), .LEDR(ledr), .LEDG(ledg)
   );

   // ---------------- scoreboard ----------------
   typedef struct {
      string          name;
      logic [SWW-1:0] ledr;
      logic [7:0]     ledg;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0, failures = 0, chk_req = 0;

   initial begin
      exp_t e;
      forever begin
         @(chk_req);
         while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (ledr !== e.ledr || ledg !== e.ledg) begin
               failures++;
               $display("FAIL %s: got ledr=%h ledg=%h, want ledr=%h ledg=%h",
                        e.name, ledr, ledg, e.ledr, e.ledg);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   // ---------------- reference model ----------------
   int          m_state, m_idx;
   logic [31:0] m_a, m_b, m_res;
   logic [3:0]  m_op;
   logic        m_z, m_n, m_v, m_sticky, m_mode;

   function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic v);
      longint sa, sb, s;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      s  = 0;
      r  = '0;
      v  = 1'b0;
      case (op)
         ALU_ADD: begin s = sa + sb; r = s[31:0]; v = (s != longint'($signed(r))); end
         ALU_SUB: begin s = sa - sb; r = s[31:0]; v = (s != longint'($signed(r))); end
         ALU_AND: r = a & b;
         ALU_OR:  r = a | b;
         ALU_XOR: r = a ^ b;
         ALU_SLL: r = a << b[4:0];
         ALU_SRL: r = a >> b[4:0];
         ALU_SLT: r = (sa < sb) ? 32'd1 : 32'd0;
         default: r = '0;
      endcase
   endfunction

   function automatic void m_goto(int s);
      if (s != m_state) m_idx = 0;
      m_state = s;
   endfunction

   function automatic void m_exec();
      logic v;
      ref_alu(m_op, m_a, m_b, m_res, v);
      m_v      = v;
      m_z      = (m_res == 0);
      m_n      = m_res[31];
      m_sticky = m_sticky | v;
      m_state  = 4;
      m_idx    = 0;
   endfunction

   function automatic void m_clear();
      m_state = 0; m_idx = 0; m_a = 0; m_b = 0; m_res = 0; m_op = 0;
      m_z = 0; m_n = 0; m_v = 0; m_sticky = 0;
   endfunction

   function automatic void m_enter(logic [15:0] v);
      case (m_state)
         0: m_a = {m_a[15:0], v};
         1: m_b = {m_b[15:0], v};
         2: m_op = v[3:0];
         4: m_exec();
         default: ;
      endcase
   endfunction

   function automatic void m_next();
      case (m_state)
         0: m_goto(1);
         1: m_goto(2);
         2: m_exec();
         4: begin
            m_a = m_mode ? m_res : 32'd0;
            m_b = 0;
            m_goto(m_mode ? 1 : 0);
         end
         default: ;
      endcase
   endfunction

   function automatic void push_exp(string name);
      exp_t        e;
      logic [31:0] view;
      case (m_state)
         0: view = m_a;
         1: view = m_b;
         2: view = {28'd0, m_op};
         default: view = m_res;
      endcase
      e.name = name;
      e.ledr = {2'(m_idx), view[m_idx*16 +: 16]};
      e.ledg = {3'(m_state), m_mode, m_sticky, m_v, m_n, m_z};
      exp_q.push_back(e);
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic check(string name);
      push_exp(name);
      chk_req++;
      #1;
   endtask

   task automatic cycles(int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic press(logic [3:0] mask, int hold = 8);
      @(negedge clk);
      key = key & ~mask;
      cycles(hold);
      @(negedge clk);
      key = 4'hF;
      cycles(5);
      @(negedge clk);
   endtask

   task automatic do_enter(logic [15:0] v);
      sw[15:0] = v;
      press(4'b0001);
      m_enter(v);
   endtask

   task automatic do_next();
      press(4'b0010);
      m_next();
   endtask

   task automatic do_win();
      press(4'b1000);
      m_idx = (m_idx + 1) % 2;
   endtask

   task automatic do_clear();
      press(4'b0100);
      m_clear();
   endtask

   task automatic set_mode(logic b);
      @(negedge clk);
      sw[17] = b;
      cycles(4);
      @(negedge clk);
      m_mode = b;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      m_clear();
      m_mode = 0;

      // reset
      cycles(3);
      @(negedge clk);
      check("reset_held");
      rst_n = 1'b1;
      cycles(2);
      @(negedge clk);
      check("reset_release");

      // press latency: pulse 6 edges after first low sample, update on the 7th
      sw[15:0] = 16'h0001;
      key[0] = 1'b0;
      cycles(7);
      @(negedge clk);
      check("latency_before");
      cycles(1);
      @(negedge clk);
      m_enter(16'h0001);
      check("latency_after");
      key = 4'hF;
      cycles(5);

      // chunked entry + ADD
      do_enter(16'h2345);
      check("load_a");
      do_next();
      do_enter(16'h0005);
      check("load_b");
      do_next();
      do_enter(16'(ALU_ADD));
      check("load_op");
      do_next();
      check("add_show");
      do_win();
      check("window_hi");
      do_win();
      check("window_wrap");

      // chain: result becomes A, B cleared
      set_mode(1'b1);
      do_next();
      check("chain_load_b");
      do_next();
      do_next();
      check("chain_result");
      set_mode(1'b0);

      // overflow and sticky
      do_next();
      do_enter(16'h7FFF);
      do_enter(16'hFFFF);
      do_next();
      do_enter(16'h0001);
      do_next();
      do_next();
      check("ovf_show");
      do_next();
      do_enter(16'h0001);
      do_next();
      do_enter(16'h0001);
      do_next();
      do_next();
      check("sticky_hold");
      do_enter(16'h0000);   // re-execute from SHOW
      check("reexec");

      // bounce: two short lows never reach the threshold
      do_next();
      @(negedge clk);
      sw[15:0] = 16'hBEEF;
      key[0] = 1'b0; cycles(3); @(negedge clk);
      key[0] = 1'b1; cycles(1); @(negedge clk);
      key[0] = 1'b0; cycles(3); @(negedge clk);
      key[0] = 1'b1; cycles(8); @(negedge clk);
      check("bounce_no_press");

      // long hold: exactly one shift
      sw[15:0] = 16'hCAFE;
      press(4'b0001, 20);
      m_enter(16'hCAFE);
      check("long_press");

      // clear beats enter
      do_next();
      do_enter(16'h1111);
      check("prio_setup");
      sw[15:0] = 16'h2222;
      press(4'b0101);
      m_clear();
      check("clear_prio");

      // randomized operations
      for (int it = 0; it < 12; it++) begin
         int nw;
         do_clear();
         do_enter(16'($urandom));
         do_enter(16'($urandom));
         do_next();
         do_enter(16'($urandom));
         do_enter(16'($urandom));
         do_next();
         do_enter(16'($urandom_range(0, 15)));
         do_next();
         check("rnd_show");
         nw = $urandom_range(0, 2);
         for (int w = 0; w < nw; w++) do_win();
         check("rnd_window");
         set_mode(1'($urandom));
         do_next();
         check("rnd_after_next");
      end
      set_mode(1'b0);

      // asynchronous reset mid-operation
      do_clear();
      do_enter(16'h00A5);
      do_next();
      do_enter(16'h005A);
      do_next();
      check("midop_setup");
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      m_clear();
      m_mode = 0;
      check("reset_midop");

      // key held through reset release gives one press after debounce
      sw[15:0] = 16'h0042;
      key[0] = 1'b0;
      cycles(2);
      @(negedge clk);
      rst_n = 1'b1;
      cycles(12);
      @(negedge clk);
      key = 4'hF;
      cycles(5);
      @(negedge clk);
      m_enter(16'h0042);
      check("held_through_reset");

      cycles(2);
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_fpga_seq.md
# alu_fpga_seq

Board-level ALU exerciser that drives the existing `alu` through `alu_if` from switches and push-buttons. It generalises operand width beyond the switch count by assembling operands from `CHUNK_W`-bit switch chunks. Entry is sequenced by a debounced button FSM (load A, load B, load op, execute, show), and results are displayed through a windowed LED view. It also adds sticky overflow and chained operation (result becomes next A).

## Interface
- `DATA_W`, 32: operand/result width; must be a multiple of `CHUNK_W`.
- `SW_W`, 18: switch/red-LED count; `CHUNK_W` ≤ `SW_W`-2.
- `CHUNK_W`, 16: switch bits shifted into an operand per enter press.
- `SYNC_STAGES`, 2: button synchroniser depth (≥2).
- `DEBOUNCE_CYC`, 500000: cycles a synced button must stay low to count as a press (10 ms @ 50 MHz); bench uses 4.
- `CLK`  in  1  system clock.
- `nRST`  in  1  asynchronous, active-low reset.
- `SW`  in  `SW_W`  data chunk in `SW[CHUNK_W-1:0]`; op code in `SW[3:0]`; chain-mode select in `SW[SW_W-1]`.
- `KEY`  in  4  active-low buttons: [0] enter, [1] next, [2] clear, [3] window.
- `LEDR`  out  `SW_W`  displayed window in `[CHUNK_W-1:0]`; window index (zero-extended) in `[SW_W-1:CHUNK_W]`.
- `LEDG`  out  8  [0] zero, [1] neg, [2] overflow (last exec), [3] sticky overflow, [4] chain mode, [7:5] state code.

## Operation
- **Button conditioning (per KEY bit).**
  - Synchroniser flops reset to 1.
  - A counter increments while the synced level is low and clears when it is high.
  - A one-cycle press pulse is emitted when the count reaches `DEBOUNCE_CYC`.
  - The button re-arms only after the synced level returns high. Exactly one pulse per press.
- **Pulse priority (same cycle):** clear > next > enter. Window is independent.
- **States and codes:** LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, SHOW=4.
- **Reset state.** State is LOAD_A. A, B, result, op, flags, sticky and window index are all 0.
- **LOAD_A / LOAD_B.**
  - enter: the target register becomes `{reg[DATA_W-CHUNK_W-1:0], SW[CHUNK_W-1:0]}`. Upper bits shift out.
  - next: advance to LOAD_B or LOAD_OP respectively.
- **LOAD_OP.**
  - enter: op ← `aluop_t'(SW[3:0])`.
  - next: go to EXEC.
- **EXEC.** Lasts exactly one cycle, then SHOW. On its closing edge:
  - result ← `OutputPort`;
  - zero/neg/overflow ← ALU flags;
  - sticky ← sticky | Overflow.
- **SHOW.**
  - enter: re-execute with the same A/B/op, going to EXEC.
  - next with `SW[SW_W-1]`=0: A, B ← 0; go to LOAD_A.
  - next with `SW[SW_W-1]`=1: A ← result, B ← 0; go to LOAD_B.
- **clear (any state).** Perform a full reset-equivalent clear, including sticky. Go to LOAD_A.
- **ALU connection.** `PortA`=A, `PortB`=B and `ALUOP`=op continuously from registers. The ALU stays combinational.
- **View word and window.**
  - View word by state: LOAD_A → A; LOAD_B → B; LOAD_OP → op zero-extended; EXEC/SHOW → result.
  - The window key advances the index modulo `DATA_W/CHUNK_W`.
  - Any state change resets the index to 0.
  - `LEDR[CHUNK_W-1:0]` = `view[idx*CHUNK_W +: CHUNK_W]`.
- **Output derivation.** LEDR/LEDG are derived only from registers. There is no combinational path from SW to LEDs except LEDG[4], which reflects the synced `SW[SW_W-1]`.

## Timing
- **Clean press latency.** The pulse is asserted `SYNC_STAGES`+`DEBOUNCE_CYC` cycles after the first edge that samples KEY low. Register/state update occurs on the next edge.
- **Bounce.** A high glitch before the count completes restarts the count. No pulse is produced.
- **Execution latency.** From a next pulse in LOAD_OP: EXEC in cycle +1, result and flags valid in SHOW at cycle +2.
- **Reset.** Reset asserted mid-operation clears everything asynchronously. The first press is recognised only after a full debounce following reset release.
- **Key held through reset.** A key held low through reset release produces one press after debounce.

## Structure
- Reuse `aluop_t`/`word_t` from `cpu_types_pkg`.
- Add a state enum `alu_seq_state_t` (codes above) to a new shared `fpga_types_pkg`.
- Instantiate the existing `alu` via `alu_if`.
- Add one sub-module, `key_cond` (synchroniser + debounce counter + press pulse), instantiated ×4.

## Test plan
- **Reset.** `DEBOUNCE_CYC`=4. Assert nRST low, then release → LEDR=0, LEDG=0, state LOAD_A.
- **Chunked entry and ADD.**
  - Stimulus: enter 0x0001, enter 0x2345, next; enter 0x0005, next; SW[3:0]=`ALU_ADD`, enter, next.
  - Response: SHOW with result 0x0001234A, LEDR[15:0]=0x234A.
  - Press window → LEDR[15:0]=0x0001, LEDR[17:16]=1.
- **Overflow and sticky.**
  - Stimulus: A=0x7FFFFFFF, B=1, ADD.
  - Response: result 0x80000000, LEDG[1]=1, [2]=1, [3]=1.
  - Then A=1, B=1 ADD → LEDG[2]=0, LEDG[3] stays 1.
- **Chain.** SW[17]=1 with next in SHOW (result 0x0001234A) → LOAD_B, A=0x0001234A, B=0, LEDG[7:5]=1.
- **Debounce and priority.**
  - KEY[0] low 3 cycles, high 1, low 3 → no pulse.
  - KEY[0] low 20 cycles → exactly one shift.
  - KEY[2] and KEY[0] pressed together in LOAD_B → all cleared, LOAD_A.
- **Reset mid-op.** nRST low in LOAD_OP with A, B nonzero → immediate clear of all registers and LEDs, before the next CLK edge.
